// File: rtl/dc_write_ctrl_pkg.sv
// Shared defaults and sizing helpers for the write side of the dual-clock
// one-hot-pointer data buffer.
package dc_write_ctrl_pkg;

   localparam int DC_DEF_DATA_WIDTH  = 32;
   localparam int DC_DEF_DEPTH       = 8;
   localparam int DC_DEF_SYNC_STAGES = 2;

   // Width of a slot index / level value; a 1-slot index still needs one bit.
   function automatic int dc_lvl_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dc_sync_vector.sv
// Per-bit multi-flop synchronizer with asynchronous reset to a chosen value.
module dc_sync_vector #(
   parameter int               WIDTH       = 8,
   parameter int               STAGES      = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [STAGES-1:0][WIDTH-1:0] r_stage;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_stage <= {STAGES{RESET_VALUE}};
      end else begin
         r_stage[0] <= i_d;
         for (int s = 1; s < STAGES; s++) begin
            r_stage[s] <= r_stage[s-1];
         end
      end
   end

   assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/dc_write_ctrl.sv
// Write-side controller: one-hot write pointer ring, synchronized read pointer,
// full/ready, registered fill level and almost_full.
module dc_write_ctrl
   import dc_write_ctrl_pkg::*;
#(
   parameter  int DATA_WIDTH      = DC_DEF_DATA_WIDTH,
   parameter  int BUFFER_DEPTH    = DC_DEF_DEPTH,
   parameter  int SYNC_STAGES     = DC_DEF_SYNC_STAGES,
   parameter  int ALMOST_FULL_THR = BUFFER_DEPTH - 2,
   localparam int LVL_W           = dc_lvl_w(BUFFER_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   output logic [BUFFER_DEPTH-1:0] write_pointer,
   output logic [DATA_WIDTH-1:0]   write_data,
   input  logic [BUFFER_DEPTH-1:0] read_pointer_async,
   output logic [LVL_W-1:0]        level,
   output logic                    almost_full
);

   // Handshake: a word transfers on a clk edge where in_valid & in_ready.
   // in_ready depends only on registers; in_data may change freely until then.

   function automatic logic [BUFFER_DEPTH-1:0] rotl1(input logic [BUFFER_DEPTH-1:0] v);
      return {v[BUFFER_DEPTH-2:0], v[BUFFER_DEPTH-1]};
   endfunction

   function automatic logic [LVL_W-1:0] encode(input logic [BUFFER_DEPTH-1:0] v);
      logic [LVL_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
         if (v[i]) idx = idx | LVL_W'(i);
      end
      return idx;
   endfunction

   function automatic logic is_onehot(input logic [BUFFER_DEPTH-1:0] v);
      return (v != '0) && ((v & (v - BUFFER_DEPTH'(1))) == '0);
   endfunction

   logic [BUFFER_DEPTH-1:0] r_wp;
   logic [LVL_W-1:0]        r_level;
   logic                    r_almost_full;

   logic [BUFFER_DEPTH-1:0] w_rp_sync;
   logic [BUFFER_DEPTH-1:0] w_wp_nxt;
   logic                    w_full;
   logic                    w_accept;
   logic [LVL_W-1:0]        w_widx;
   logic [LVL_W-1:0]        w_ridx;
   logic [LVL_W:0]          w_diff;
   logic [LVL_W-1:0]        w_level_nxt;
   logic                    w_af_nxt;

   // Reset value 1 matches the read side's reset pointer (slot 0).
   dc_sync_vector #(
      .WIDTH       (BUFFER_DEPTH),
      .STAGES      (SYNC_STAGES),
      .RESET_VALUE (BUFFER_DEPTH'(1))
   ) u_rp_sync (
      .clk  (clk),
      .rstn (rstn),
      .i_d  (read_pointer_async),
      .o_q  (w_rp_sync)
   );

   // OR form keeps a two-hot transient conservative (reads as full).
   assign w_wp_nxt = rotl1(r_wp);
   assign w_full   = |(w_wp_nxt & w_rp_sync);
   assign w_accept = in_valid & ~w_full;

   assign w_widx = encode(r_wp);
   assign w_ridx = encode(w_rp_sync);

   always_comb begin
      w_diff = '0;
      if (w_widx >= w_ridx) begin
         w_diff = {1'b0, w_widx} - {1'b0, w_ridx};
      end else begin
         w_diff = {1'b0, w_widx} + (LVL_W+1)'(BUFFER_DEPTH) - {1'b0, w_ridx};
      end
   end

   // A pointer caught mid-transition is not a valid index; keep the old level.
   assign w_level_nxt = is_onehot(w_rp_sync) ? w_diff[LVL_W-1:0] : r_level;
   assign w_af_nxt    = (int'(w_level_nxt) >= ALMOST_FULL_THR);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wp          <= BUFFER_DEPTH'(1);
         r_level       <= '0;
         r_almost_full <= (ALMOST_FULL_THR == 0);
      end else begin
         if (w_accept) begin
            r_wp <= w_wp_nxt;
         end
         r_level       <= w_level_nxt;
         r_almost_full <= w_af_nxt;
      end
   end

   assign in_ready      = ~w_full;
   assign write_pointer = r_wp;
   assign write_data    = in_data;
   assign level         = r_level;
   assign almost_full   = r_almost_full;

endmodule

// File: tb/tb_dc_write_ctrl.sv
// Self-checking bench for dc_write_ctrl: vector table, corner sequences and
// randomized traffic against a slot-index model with a behavioural buffer.
module tb_dc_write_ctrl;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int SYNC  = 2;
   localparam int THR   = DEPTH - 2;

   logic             clk;
   logic             rstn;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in_data;
   logic [DEPTH-1:0] write_pointer;
   logic [DW-1:0]    write_data;
   logic [DEPTH-1:0] read_pointer_async;
   logic [2:0]       level;
   logic             almost_full;

   dc_write_ctrl #(
      .DATA_WIDTH      (DW),
      .BUFFER_DEPTH    (DEPTH),
      .SYNC_STAGES     (SYNC),
      .ALMOST_FULL_THR (THR)
   ) dut (
      .clk                (clk),
      .rstn               (rstn),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_data            (in_data),
      .write_pointer      (write_pointer),
      .write_data         (write_data),
      .read_pointer_async (read_pointer_async),
      .level              (level),
      .almost_full        (almost_full)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int enc(input logic [DEPTH-1:0] v);
      int idx;
      idx = 0;
      for (int i = 0; i < DEPTH; i++) if (v[i]) idx = i;
      return idx;
   endfunction

   // Behavioural buffer: writes slot write_pointer with write_data every edge.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (rstn) mem[enc(write_pointer)] <= write_data;
   end

   typedef struct {
      logic          valid;
      logic [DW-1:0] data;
      logic [7:0]    rp;
      logic [7:0]    wp;
      logic          rdy;
      logic [2:0]    lvl;
      logic          af;
   } vec_t;

   vec_t vecs [9];

   // driver tasks
   task automatic drive(input logic v, input logic [DW-1:0] d, input logic [7:0] rp);
      in_valid           = v;
      in_data            = d;
      read_pointer_async = rp;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      drive(1'b0, '0, 8'h01);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic check_state(input string tag, input logic [7:0] wp, input logic rdy,
                              input logic [2:0] lvl, input logic af);
      check({tag, ".wp"},    32'(write_pointer), 32'(wp));
      check({tag, ".ready"}, 32'(in_ready),      32'(rdy));
      check({tag, ".level"}, 32'(level),         32'(lvl));
      check({tag, ".af"},    32'(almost_full),   32'(af));
   endtask

   // scoreboard / reference model state
   logic [DW-1:0]    exp_q [$];
   logic [DEPTH-1:0] sq [$];
   int               mw, rd, m_level;
   logic             m_af, m_rdy, m_acc;
   logic [DEPTH-1:0] rs;

   initial begin
      vecs[0] = '{1'b1, 32'hA000_0000, 8'h01, 8'h02, 1'b1, 3'd0, 1'b0};
      vecs[1] = '{1'b1, 32'hA000_0001, 8'h01, 8'h04, 1'b1, 3'd1, 1'b0};
      vecs[2] = '{1'b1, 32'hA000_0002, 8'h01, 8'h08, 1'b1, 3'd2, 1'b0};
      vecs[3] = '{1'b1, 32'hA000_0003, 8'h01, 8'h10, 1'b1, 3'd3, 1'b0};
      vecs[4] = '{1'b1, 32'hA000_0004, 8'h01, 8'h20, 1'b1, 3'd4, 1'b0};
      vecs[5] = '{1'b1, 32'hA000_0005, 8'h01, 8'h40, 1'b1, 3'd5, 1'b0};
      vecs[6] = '{1'b1, 32'hA000_0006, 8'h01, 8'h80, 1'b0, 3'd6, 1'b1};
      vecs[7] = '{1'b1, 32'hA000_0007, 8'h01, 8'h80, 1'b0, 3'd7, 1'b1};
      vecs[8] = '{1'b1, 32'hA000_0008, 8'h01, 8'h80, 1'b0, 3'd7, 1'b1};

      rstn = 1'b0;
      drive(1'b0, '0, 8'h01);

      // reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_low.wp", 32'(write_pointer), 32'h01);
      rstn = 1'b1;
      #1;
      check_state("reset", 8'h01, 1'b1, 3'd0, 1'b0);
      @(negedge clk);

      // fill from empty with a static read pointer
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].valid, vecs[i].data, vecs[i].rp);
         #1;
         check($sformatf("vec%0d.wdata", i), write_data, vecs[i].data);
         tick();
         check_state($sformatf("vec%0d", i), vecs[i].wp, vecs[i].rdy, vecs[i].lvl, vecs[i].af);
      end
      for (int s = 0; s < 7; s++) begin
         check($sformatf("slot%0d", s), mem[s], 32'hA000_0000 + 32'(s));
      end

      // read advance becomes visible after exactly SYNC edges, then wrap
      drive(1'b0, 32'hB000_0000, 8'h02);
      tick();
      check("sync1.ready", 32'(in_ready), 32'h0);
      tick();
      check("sync2.ready", 32'(in_ready), 32'h1);
      check("sync2.wp",    32'(write_pointer), 32'h80);
      drive(1'b1, 32'hB000_0001, 8'h02);
      tick();
      check("wrap.wp",    32'(write_pointer), 32'h01);
      check("wrap.ready", 32'(in_ready), 32'h0);
      check("slot7",      mem[7], 32'hB000_0001);

      // two-hot read pointer for one cycle while full
      drive(1'b1, 32'hC000_0000, 8'h03);
      tick();
      check_state("twohot0", 8'h01, 1'b0, 3'd7, 1'b1);
      drive(1'b1, 32'hC000_0001, 8'h02);
      for (int k = 1; k < 4; k++) begin
         tick();
         check_state($sformatf("twohot%0d", k), 8'h01, 1'b0, 3'd7, 1'b1);
      end

      // asynchronous reset mid-burst at level 4
      do_reset();
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'hD000_0000 + 32'(i), 8'h01);
         tick();
      end
      check("midburst.level", 32'(level), 32'h4);
      rstn = 1'b0;
      #1;
      check_state("async_rst", 8'h01, 1'b1, 3'd0, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      drive(1'b0, '0, 8'h01);
      tick();
      check_state("post_rst", 8'h01, 1'b1, 3'd0, 1'b0);

      // randomized traffic against the model
      do_reset();
      @(negedge clk);
      mw = 0; rd = 0; m_level = 0; m_af = 1'b0;
      exp_q.delete();
      sq.delete();
      for (int i = 0; i < SYNC; i++) sq.push_back(8'h01);
      for (int c = 0; c < 2000; c++) begin
         check("rnd.wp",    32'(write_pointer), 32'(8'(1) << mw));
         check("rnd.ready", 32'(in_ready), 32'(!sq[0][(mw + 1) % DEPTH]));
         check("rnd.level", 32'(level), 32'(m_level));
         check("rnd.af",    32'(almost_full), 32'(m_af));
         if (rd != mw && $urandom_range(0, 3) < (((c / 250) % 2 == 0) ? 1 : 3)) begin
            if (exp_q.size() == 0) begin
               check("rnd.exp_q_empty", 32'(exp_q.size()), 32'h1);
            end else begin
               check("rnd.rdata", mem[rd], exp_q.pop_front());
            end
            rd = (rd + 1) % DEPTH;
         end
         drive($urandom_range(0, 3) != 0, $urandom(), 8'(1) << rd);
         rs    = sq[0];
         m_rdy = !rs[(mw + 1) % DEPTH];
         m_acc = in_valid && m_rdy;
         if (m_acc) exp_q.push_back(in_data);
         @(posedge clk);
         if ($countones(rs) == 1) m_level = (mw - enc(rs) + DEPTH) % DEPTH;
         m_af = (m_level >= THR);
         if (m_acc) mw = (mw + 1) % DEPTH;
         sq.push_back(read_pointer_async);
         void'(sq.pop_front());
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
